// File: rtl/ulpb_tx_sched_pkg.sv
// Shared definitions for the ULPB member-node transmit scheduler:
// state encodings (visible on test_pt), timing defaults and sizing helpers.
package ulpb_tx_sched_pkg;

  localparam int IDLE_CYCLES_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ_BUS   = 3'd1,
    ST_ARBI      = 3'd2,
    ST_TX        = 3'd3,
    ST_WAIT_END  = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // Bits on the wire per frame: address first, then data.
  function automatic int frame_len(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  // Index width for v distinct values, never narrower than one bit.
  function automatic int ulpb_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/ulpb_tx_sched_rr_arbiter.sv
// Round-robin one-hot picker: grants the first set request at or after ptr,
// wrapping past NUM_REQ-1 back to 0.
module ulpb_rr_arbiter
  import ulpb_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = ulpb_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               vld
);

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int ofs);
    int s;
    s = (32'(base) + ofs) % NUM_REQ;
    return PTR_W'(s);
  endfunction

  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    vld     = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap_idx(ptr, k);
      if (!vld && req[idx]) begin
        vld      = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ulpb_tx_sched.sv
// ULPB member-node transmit scheduler: picks a local requester round-robin,
// requests the ring, resolves arbitration and shifts the frame out on DOUT.
module ulpb_tx_sched
  import ulpb_tx_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             BUS_CLK,
  input  logic                             DIN,
  output logic                             DOUT,
  input  logic [NUM_REQ-1:0]               REQ,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    DATA,
  output logic [NUM_REQ-1:0]               GNT,
  output logic [NUM_REQ-1:0]               ACK,
  output logic [NUM_REQ-1:0]               FAIL,
  output logic                             BUSY,
  output logic [2:0]                       test_pt
);

  localparam int FRAME = frame_len(ADDR_WIDTH, DATA_WIDTH);
  localparam int BC_W  = ulpb_clog2(FRAME + 1);
  localparam int IC_W  = ulpb_clog2(IDLE_CYCLES + 1);
  localparam int PTR_W = ulpb_clog2(NUM_REQ);

  state_t               state, state_nx;
  logic                 drive, drive_nx;
  logic                 tx_bit;
  logic [FRAME-1:0]     shift_reg;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_nx, ptr_after;
  logic [NUM_REQ-1:0]   owner, owner_nx;
  logic [NUM_REQ-1:0]   gnt_nx, ack_nx, fail_nx;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_nx;
  logic                 bus_clk_d;
  logic [IC_W-1:0]      idle_cnt;
  logic                 fall, rise, idle_done;
  logic                 load_frame, shift_bit;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_vld;
  logic [FRAME-1:0]     win_frame;

  function automatic logic [IC_W-1:0] sat_inc(input logic [IC_W-1:0] v);
    return (v == IC_W'(IDLE_CYCLES)) ? v : v + 1'b1;
  endfunction

  ulpb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (REQ),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .vld     (arb_vld)
  );

  assign fall      = bus_clk_d & ~BUS_CLK;
  assign rise      = ~bus_clk_d & BUS_CLK;
  assign idle_done = (idle_cnt == IC_W'(IDLE_CYCLES));
  assign ptr_after = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  assign DOUT    = drive ? tx_bit : DIN;
  assign BUSY    = (state != ST_IDLE);
  assign test_pt = state;

  // Winner's address+data, only consumed in the grant cycle.
  always_comb begin
    win_frame = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_gnt[k]) begin
        win_frame = {ADDR[k*ADDR_WIDTH +: ADDR_WIDTH], DATA[k*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  always_comb begin
    state_nx   = state;
    drive_nx   = drive;
    rr_ptr_nx  = rr_ptr;
    owner_nx   = owner;
    bit_cnt_nx = bit_cnt;
    gnt_nx     = '0;
    ack_nx     = '0;
    fail_nx    = '0;
    load_frame = 1'b0;
    shift_bit  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // DIN low means another node already holds the ring request.
        if (arb_vld && DIN) begin
          load_frame = 1'b1;
          gnt_nx     = arb_gnt;
          owner_nx   = arb_gnt;
          drive_nx   = 1'b1;
          rr_ptr_nx  = ptr_after;
          bit_cnt_nx = '0;
          state_nx   = ST_REQ_BUS;
        end
      end
      ST_REQ_BUS: begin
        if (fall) begin
          state_nx = ST_ARBI;
        end else if (idle_done) begin
          drive_nx = 1'b0;
          fail_nx  = owner;
          state_nx = ST_WAIT_IDLE;
        end
      end
      ST_ARBI: begin
        if (rise) begin
          if (DIN) begin
            state_nx = ST_TX;
          end else begin
            drive_nx = 1'b0;
            fail_nx  = owner;
            state_nx = ST_WAIT_IDLE;
          end
        end
      end
      ST_TX: begin
        // A stalled bus clock mid-frame means the controller aborted.
        if (idle_done) begin
          drive_nx = 1'b0;
          fail_nx  = owner;
          state_nx = ST_WAIT_IDLE;
        end else if (fall && (bit_cnt != BC_W'(FRAME))) begin
          shift_bit  = 1'b1;
          bit_cnt_nx = bit_cnt + 1'b1;
        end else if (rise && (bit_cnt == BC_W'(FRAME))) begin
          drive_nx = 1'b0;
          state_nx = ST_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        if (idle_done && DIN) begin
          ack_nx   = owner;
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (idle_done && DIN) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        drive_nx = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      drive     <= 1'b0;
      rr_ptr    <= '0;
      owner     <= '0;
      bit_cnt   <= '0;
      bus_clk_d <= 1'b1;
      idle_cnt  <= '0;
      GNT       <= '0;
      ACK       <= '0;
      FAIL      <= '0;
    end else begin
      state     <= state_nx;
      drive     <= drive_nx;
      rr_ptr    <= rr_ptr_nx;
      owner     <= owner_nx;
      bit_cnt   <= bit_cnt_nx;
      bus_clk_d <= BUS_CLK;
      GNT       <= gnt_nx;
      ACK       <= ack_nx;
      FAIL      <= fail_nx;
      if (fall || rise) begin
        idle_cnt <= '0;
      end else if (BUS_CLK) begin
        idle_cnt <= sat_inc(idle_cnt);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (load_frame) begin
      shift_reg <= win_frame;
      tx_bit    <= 1'b0;
    end else if (shift_bit) begin
      tx_bit    <= shift_reg[FRAME-1];
      shift_reg <= {shift_reg[FRAME-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_ulpb_tx_sched.sv
// Directed + randomized bench for ulpb_tx_sched; the bench plays the bus
// controller and upstream ring, and models round-robin and frame order itself.
module tb_ulpb_tx_sched;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IC = 12;
  localparam int FL = AW + DW;
  // Edge sample, IC quiet high samples to saturate, one registered reaction.
  localparam int QUIET_LAT = IC + 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              BUS_CLK;
  logic              DIN;
  logic              DOUT;
  logic [N-1:0]      REQ;
  logic [N*AW-1:0]   ADDR;
  logic [N*DW-1:0]   DATA;
  logic [N-1:0]      GNT;
  logic [N-1:0]      ACK;
  logic [N-1:0]      FAIL;
  logic              BUSY;
  logic [2:0]        test_pt;

  int n_assert = 0;
  int n_fail   = 0;
  int rr_m     = 0;

  ulpb_tx_sched #(
    .NUM_REQ     (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .IDLE_CYCLES (IC)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .BUS_CLK (BUS_CLK),
    .DIN     (DIN),
    .DOUT    (DOUT),
    .REQ     (REQ),
    .ADDR    (ADDR),
    .DATA    (DATA),
    .GNT     (GNT),
    .ACK     (ACK),
    .FAIL    (FAIL),
    .BUSY    (BUSY),
    .test_pt (test_pt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(rr_m + k) % N]) return (rr_m + k) % N;
    end
    return 0;
  endfunction

  task automatic do_grant(input logic [N-1:0] req, input bit rnd,
                          output int w, output logic [FL-1:0] frame);
    if (rnd) begin
      for (int k = 0; k < N; k++) begin
        ADDR[k*AW +: AW] = AW'($urandom);
        DATA[k*DW +: DW] = $urandom;
      end
    end
    REQ   = req;
    w     = rr_pick(req);
    frame = {ADDR[w*AW +: AW], DATA[w*DW +: DW]};
    step();
    chk("gnt", 64'(GNT), 64'(N'(1) << w));
    chk("req_pull_low", 64'(DOUT), 64'(0));
    chk("busy_on_grant", 64'(BUSY), 64'(1));
    chk("st_req_bus", 64'(test_pt), 64'(1));
    rr_m = (w + 1) % N;
    ADDR = ~ADDR;
    DATA = ~DATA;
  endtask

  task automatic arb_phase(input logic din);
    BUS_CLK = 1'b0;
    step();
    chk("st_arbi", 64'(test_pt), 64'(2));
    chk("arbi_low", 64'(DOUT), 64'(0));
    step();
    BUS_CLK = 1'b1;
    DIN     = din;
  endtask

  task automatic send_bits(input logic [FL-1:0] frame, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      step();
      step();
      if (b == 0) chk("st_tx", 64'(test_pt), 64'(3));
      BUS_CLK = 1'b0;
      step();
      step();
      chk($sformatf("bit%0d", b), 64'(DOUT), 64'(frame[FL-1-b]));
      BUS_CLK = 1'b1;
    end
  endtask

  task automatic wait_pulse(input bit is_fail, input logic [N-1:0] mask,
                            input int exp_steps, input string tag);
    int seen;
    int stray;
    logic [N-1:0] got;
    seen  = 0;
    stray = 0;
    got   = '0;
    for (int i = 1; i <= exp_steps + 4 && seen == 0; i++) begin
      step();
      if ((is_fail ? ACK : FAIL) != '0 || GNT != '0) stray++;
      if ((is_fail ? FAIL : ACK) != '0) begin
        seen = i;
        got  = is_fail ? FAIL : ACK;
      end
    end
    chk({tag, "_who"}, 64'(got), 64'(mask));
    chk({tag, "_latency"}, 64'(seen), 64'(exp_steps));
    chk({tag, "_stray"}, 64'(stray), 64'(0));
  endtask

  task automatic wait_idle(input int exp_steps, input string tag);
    int seen;
    int stray;
    seen  = 0;
    stray = 0;
    for (int i = 1; i <= exp_steps + 4 && seen == 0; i++) begin
      step();
      if (ACK != '0 || FAIL != '0 || GNT != '0) stray++;
      if (test_pt == 3'd0) seen = i;
    end
    chk({tag, "_latency"}, 64'(seen), 64'(exp_steps));
    chk({tag, "_stray"}, 64'(stray), 64'(0));
    chk({tag, "_busy"}, 64'(BUSY), 64'(0));
  endtask

  task automatic full_frame(input logic [N-1:0] req, input bit rnd);
    int w;
    logic [FL-1:0] fr;
    do_grant(req, rnd, w, fr);
    arb_phase(1'b1);
    send_bits(fr, FL);
    step();
    chk("st_wait_end", 64'(test_pt), 64'(4));
    chk("wait_end_follow", 64'(DOUT), 64'(DIN));
    DIN = 1'b0;
    #1;
    chk("wait_end_follow_low", 64'(DOUT), 64'(0));
    DIN = 1'b1;
    wait_pulse(1'b0, N'(1) << w, QUIET_LAT - 1, "ack");
    chk("idle_after_ack", 64'(test_pt), 64'(0));
  endtask

  initial begin
    int w;
    logic [FL-1:0] fr;
    RESET   = 1'b0;
    BUS_CLK = 1'b1;
    DIN     = 1'b1;
    REQ     = '0;
    ADDR    = '0;
    DATA    = '0;
    step();
    chk("rst_dout", 64'(DOUT), 64'(1));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_state", 64'(test_pt), 64'(0));
    chk("rst_pulses", 64'({GNT, ACK, FAIL}), 64'(0));
    DIN = 1'b0;
    #1;
    chk("rst_dout_follow", 64'(DOUT), 64'(0));
    DIN = 1'b1;
    step();
    RESET = 1'b1;
    step();
    step();

    // Single requester with a known frame, then round-robin under contention.
    ADDR[AW-1:0] = 8'hA5;
    DATA[DW-1:0] = 32'h1234_5678;
    full_frame(2'b01, 1'b0);
    full_frame(2'b11, 1'b1);
    full_frame(2'b11, 1'b1);
    full_frame(2'b11, 1'b1);

    // Ring already requested upstream: no grant while DIN is low.
    REQ = 2'b01;
    DIN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_no_gnt", 64'(GNT), 64'(0));
      chk("hold_idle", 64'(test_pt), 64'(0));
    end
    DIN = 1'b1;
    full_frame(2'b01, 1'b1);

    // Arbitration lost to an upstream node.
    do_grant(2'b10, 1'b1, w, fr);
    arb_phase(1'b0);
    wait_pulse(1'b1, N'(1) << w, 1, "arb_lose");
    REQ = '0;
    chk("lose_follow_low", 64'(DOUT), 64'(0));
    DIN = 1'b1;
    #1;
    chk("lose_follow_high", 64'(DOUT), 64'(1));
    wait_idle(IC + 1, "lose_idle");

    // Bus clock stops after ten bits.
    do_grant(2'b11, 1'b1, w, fr);
    arb_phase(1'b1);
    send_bits(fr, 10);
    wait_pulse(1'b1, N'(1) << w, QUIET_LAT, "stall");
    REQ = '0;
    chk("stall_release", 64'(DOUT), 64'(DIN));
    DIN = 1'b0;
    #1;
    chk("stall_release_low", 64'(DOUT), 64'(0));
    DIN = 1'b1;
    wait_idle(1, "stall_idle");

    // Reset mid-frame.
    do_grant(2'b01, 1'b1, w, fr);
    arb_phase(1'b1);
    send_bits(fr, 5);
    step();
    RESET   = 1'b0;
    BUS_CLK = 1'b1;
    REQ     = '0;
    #1;
    chk("mid_rst_busy", 64'(BUSY), 64'(0));
    chk("mid_rst_state", 64'(test_pt), 64'(0));
    chk("mid_rst_pulses", 64'({GNT, ACK, FAIL}), 64'(0));
    DIN = 1'b0;
    #1;
    chk("mid_rst_dout_low", 64'(DOUT), 64'(0));
    DIN = 1'b1;
    #1;
    chk("mid_rst_dout_high", 64'(DOUT), 64'(1));
    rr_m = 0;
    step();
    step();
    RESET = 1'b1;
    step();
    chk("post_rst_pulses", 64'({GNT, ACK, FAIL}), 64'(0));
    full_frame(2'b11, 1'b1);

    // Randomized request patterns and payloads.
    for (int i = 0; i < 4; i++) begin
      full_frame(N'($urandom_range(1, (1 << N) - 1)), 1'b1);
    end
    REQ = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
